pipeline_hazard_controller: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_controller_pkg.sv | 71 +++++++
 rtl/pipeline_hazard_controller_load_use.sv | 23 ++
 rtl/pipeline_hazard_controller.sv | 170 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// the bundle of per-register control strobes, and the canned strobe patterns.
package pipeline_hazard_controller_pkg;

  localparam int HC_STATE_BITS         = 2;
  localparam int HC_NUM_REGISTERS_LOG2 = 5;

  typedef enum logic [HC_STATE_BITS-1:0] {
    HC_RUN      = 2'd0,
    HC_MEM_WAIT = 2'd1,
    HC_ERROR    = 2'd2
  } hc_state_t;

  // One stall/flush/nop triple per pipeline register, plus the PC strobes.
  typedef struct packed {
    logic pc_stall;
    logic pc_redirect;
    logic if_id_stall;
    logic if_id_flush;
    logic if_id_nop;
    logic id_ex_stall;
    logic id_ex_flush;
    logic id_ex_nop;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic ex_mem_nop;
    logic mem_wb_stall;
    logic mem_wb_flush;
    logic mem_wb_nop;
  } hc_ctrl_t;

  localparam hc_ctrl_t HC_CTRL_IDLE = '0;

  // Reset: hold PC, every register flushed to a nop, nothing stalled.
  localparam hc_ctrl_t HC_CTRL_RESET = '{
    pc_stall: 1'b1, pc_redirect: 1'b0,
    if_id_stall: 1'b0,  if_id_flush: 1'b1,  if_id_nop: 1'b1,
    id_ex_stall: 1'b0,  id_ex_flush: 1'b1,  id_ex_nop: 1'b1,
    ex_mem_stall: 1'b0, ex_mem_flush: 1'b1, ex_mem_nop: 1'b1,
    mem_wb_stall: 1'b0, mem_wb_flush: 1'b1, mem_wb_nop: 1'b1
  };

  // Data-memory wait: freeze everything up to EX/MEM, feed bubbles into WB.
  // MEM/WB takes a flush rather than a stall so the two never collide.
  localparam hc_ctrl_t HC_CTRL_WAIT = '{
    pc_stall: 1'b1, pc_redirect: 1'b0,
    if_id_stall: 1'b1,  if_id_flush: 1'b0,  if_id_nop: 1'b0,
    id_ex_stall: 1'b1,  id_ex_flush: 1'b0,  id_ex_nop: 1'b0,
    ex_mem_stall: 1'b1, ex_mem_flush: 1'b0, ex_mem_nop: 1'b0,
    mem_wb_stall: 1'b0, mem_wb_flush: 1'b1, mem_wb_nop: 1'b0
  };

  // Mispredict: load the resolved target and squash the two younger stages.
  localparam hc_ctrl_t HC_CTRL_REDIRECT = '{
    pc_stall: 1'b0, pc_redirect: 1'b1,
    if_id_stall: 1'b0,  if_id_flush: 1'b1,  if_id_nop: 1'b0,
    id_ex_stall: 1'b0,  id_ex_flush: 1'b1,  id_ex_nop: 1'b0,
    ex_mem_stall: 1'b0, ex_mem_flush: 1'b0, ex_mem_nop: 1'b0,
    mem_wb_stall: 1'b0, mem_wb_flush: 1'b0, mem_wb_nop: 1'b0
  };

  // Load-use: hold the consumer in ID for one cycle, bubble into EX.
  localparam hc_ctrl_t HC_CTRL_LOAD_USE = '{
    pc_stall: 1'b1, pc_redirect: 1'b0,
    if_id_stall: 1'b1,  if_id_flush: 1'b0,  if_id_nop: 1'b0,
    id_ex_stall: 1'b0,  id_ex_flush: 1'b1,  id_ex_nop: 1'b0,
    ex_mem_stall: 1'b0, ex_mem_flush: 1'b0, ex_mem_nop: 1'b0,
    mem_wb_stall: 1'b0, mem_wb_flush: 1'b0, mem_wb_nop: 1'b0
  };

endpackage

// File: rtl/pipeline_hazard_controller_load_use.sv
// Load-use hazard compare: the load in EX writes a register the ID
// instruction reads. Register 0 is hardwired and never creates a hazard.
module hazard_load_use_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_W = HC_NUM_REGISTERS_LOG2
) (
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_mem_to_reg,
  input  logic [REG_W-1:0] i_ex_reg_dst,
  output logic             o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_reg_dst == i_id_rs);
  assign w_rt_match = i_id_uses_rt & (i_ex_reg_dst == i_id_rt);
  assign o_load_use = i_ex_mem_to_reg & (i_ex_reg_dst != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers:
// resolves load-use, mispredict and data-memory wait hazards, keeps
// saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int NUM_REGISTERS_LOG2 = HC_NUM_REGISTERS_LOG2,
  parameter int CNT_WIDTH          = 32,
  parameter int MEM_TIMEOUT        = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REGISTERS_LOG2-1:0] id_rs,
  input  logic [NUM_REGISTERS_LOG2-1:0] id_rt,
  input  logic                          id_uses_rt,
  input  logic                          ex_mem_to_reg,
  input  logic [NUM_REGISTERS_LOG2-1:0] ex_reg_dst,
  input  logic                          mem_req,
  input  logic                          mem_ready,
  input  logic                          mispredict,
  output logic                          pc_stall,
  output logic                          pc_redirect,
  output logic                          if_id_stall,
  output logic                          if_id_flush,
  output logic                          if_id_nop,
  output logic                          id_ex_stall,
  output logic                          id_ex_flush,
  output logic                          id_ex_nop,
  output logic                          ex_mem_stall,
  output logic                          ex_mem_flush,
  output logic                          ex_mem_nop,
  output logic                          mem_wb_stall,
  output logic                          mem_wb_flush,
  output logic                          mem_wb_nop,
  output logic [HC_STATE_BITS-1:0]      state,
  output logic [CNT_WIDTH-1:0]          stall_count,
  output logic [CNT_WIDTH-1:0]          flush_count,
  output logic                          mem_timeout
);

  hc_state_t            r_state;
  logic                 r_pending;
  logic [15:0]          r_wait_cnt;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;
  logic                 r_mem_timeout;

  hc_state_t   w_state_next;
  logic        w_pending_next;
  logic [15:0] w_wait_next;
  logic [16:0] w_wait_inc;
  logic        w_timeout_hit;
  logic        w_flush_inc;
  logic        w_stall_inc;
  logic        w_load_use;
  hc_ctrl_t    w_ctrl;

  hazard_load_use_detect #(
    .REG_W(NUM_REGISTERS_LOG2)
  ) u_load_use (
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rt   (id_uses_rt),
    .i_ex_mem_to_reg(ex_mem_to_reg),
    .i_ex_reg_dst   (ex_reg_dst),
    .o_load_use     (w_load_use)
  );

  // The cycle entering a wait from RUN is wait cycle 1; each further
  // unready MEM_WAIT cycle adds one. Reaching MEM_TIMEOUT means error.
  assign w_wait_inc    = (r_state == HC_RUN) ? 17'd1 : {1'b0, r_wait_cnt} + 17'd1;
  assign w_timeout_hit = (w_wait_inc >= 17'(MEM_TIMEOUT));

  // Next-state and control strobes from current state and hazard inputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    w_ctrl         = HC_CTRL_IDLE;
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_wait_next    = r_wait_cnt;
    w_flush_inc    = 1'b0;
    if (!reset_n) begin
      w_ctrl = HC_CTRL_RESET;
    end else begin
      unique case (r_state)
        HC_RUN: begin
          if (mem_req && !mem_ready) begin
            w_ctrl         = HC_CTRL_WAIT;
            w_pending_next = mispredict;
            w_wait_next    = w_wait_inc[15:0];
            w_state_next   = w_timeout_hit ? HC_ERROR : HC_MEM_WAIT;
          end else if (mispredict) begin
            w_ctrl      = HC_CTRL_REDIRECT;
            w_flush_inc = 1'b1;
          end else if (w_load_use) begin
            w_ctrl = HC_CTRL_LOAD_USE;
          end
        end
        HC_MEM_WAIT: begin
          if (mem_ready) begin
            // Release cycle: a deferred (or fresh) redirect beats load-use.
            if (r_pending || mispredict) begin
              w_ctrl      = HC_CTRL_REDIRECT;
              w_flush_inc = 1'b1;
            end else if (w_load_use) begin
              w_ctrl = HC_CTRL_LOAD_USE;
            end
            w_pending_next = 1'b0;
            w_wait_next    = '0;
            w_state_next   = HC_RUN;
          end else begin
            w_ctrl         = HC_CTRL_WAIT;
            w_pending_next = r_pending | mispredict;
            w_wait_next    = w_wait_inc[15:0];
            w_state_next   = w_timeout_hit ? HC_ERROR : HC_MEM_WAIT;
          end
        end
        HC_ERROR: begin
          w_ctrl = HC_CTRL_WAIT;
        end
        default: begin
          w_ctrl       = HC_CTRL_WAIT;
          w_state_next = HC_ERROR;
        end
      endcase
    end
  end

  assign w_stall_inc = w_ctrl.pc_stall & (r_state != HC_ERROR);

  // State, wait counter, pending redirect, perf counters and error flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state       <= HC_RUN;
      r_pending     <= 1'b0;
      r_wait_cnt    <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pending_next;
      r_wait_cnt <= w_wait_next;
      if (w_stall_inc && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
      if (w_flush_inc && (r_flush_count != '1)) r_flush_count <= r_flush_count + 1'b1;
      if (w_state_next == HC_ERROR) r_mem_timeout <= 1'b1;
    end
  end

  assign pc_stall     = w_ctrl.pc_stall;
  assign pc_redirect  = w_ctrl.pc_redirect;
  assign if_id_stall  = w_ctrl.if_id_stall;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign if_id_nop    = w_ctrl.if_id_nop;
  assign id_ex_stall  = w_ctrl.id_ex_stall;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign id_ex_nop    = w_ctrl.id_ex_nop;
  assign ex_mem_stall = w_ctrl.ex_mem_stall;
  assign ex_mem_flush = w_ctrl.ex_mem_flush;
  assign ex_mem_nop   = w_ctrl.ex_mem_nop;
  assign mem_wb_stall = w_ctrl.mem_wb_stall;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;
  assign mem_wb_nop   = w_ctrl.mem_wb_nop;
  assign state        = r_state;
  assign stall_count  = r_stall_count;
  assign flush_count  = r_flush_count;
  assign mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with MEM_TIMEOUT=4.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, ex_reg_dst;
  logic        id_uses_rt, ex_mem_to_reg, mem_req, mem_ready, mispredict;
  logic        pc_stall, pc_redirect;
  logic        if_id_stall, if_id_flush, if_id_nop;
  logic        id_ex_stall, id_ex_flush, id_ex_nop;
  logic        ex_mem_stall, ex_mem_flush, ex_mem_nop;
  logic        mem_wb_stall, mem_wb_flush, mem_wb_nop;
  logic [1:0]  state;
  logic [31:0] stall_count, flush_count;
  logic        mem_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Bit order: pc_stall, pc_redirect, then stall/flush/nop for IF/ID, ID/EX, EX/MEM, MEM/WB.
  localparam logic [13:0] C_RESET = 14'b10_011_011_011_011;
  localparam logic [13:0] C_IDLE  = 14'b00_000_000_000_000;
  localparam logic [13:0] C_WAIT  = 14'b10_100_100_100_010;
  localparam logic [13:0] C_REDIR = 14'b01_010_010_000_000;
  localparam logic [13:0] C_LU    = 14'b10_100_010_000_000;

  logic [13:0] ctrl;
  assign ctrl = {pc_stall, pc_redirect,
                 if_id_stall, if_id_flush, if_id_nop,
                 id_ex_stall, id_ex_flush, id_ex_nop,
                 ex_mem_stall, ex_mem_flush, ex_mem_nop,
                 mem_wb_stall, mem_wb_flush, mem_wb_nop};

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .NUM_REGISTERS_LOG2(5),
    .CNT_WIDTH         (32),
    .MEM_TIMEOUT       (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_dst   (ex_reg_dst),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mispredict   (mispredict),
    .pc_stall     (pc_stall),
    .pc_redirect  (pc_redirect),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .if_id_nop    (if_id_nop),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .id_ex_nop    (id_ex_nop),
    .ex_mem_stall (ex_mem_stall),
    .ex_mem_flush (ex_mem_flush),
    .ex_mem_nop   (ex_mem_nop),
    .mem_wb_stall (mem_wb_stall),
    .mem_wb_flush (mem_wb_flush),
    .mem_wb_nop   (mem_wb_nop),
    .state        (state),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .mem_timeout  (mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the falling edge, apply one cycle of inputs, let outputs settle.
  task automatic drive(input logic mreq, input logic mrdy, input logic mispr,
                       input logic ld, input logic [4:0] dst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt);
    @(negedge clk);
    mem_req = mreq; mem_ready = mrdy; mispredict = mispr;
    ex_mem_to_reg = ld; ex_reg_dst = dst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; mispredict = 1'b0;
    ex_mem_to_reg = 1'b0; ex_reg_dst = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;

    // 1. Reset for two cycles, then release.
    idle();
    check("rst_ctrl_c1", {18'd0, ctrl}, {18'd0, C_RESET});
    idle();
    check("rst_ctrl_c2", {18'd0, ctrl}, {18'd0, C_RESET});
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_stall_cnt", stall_count, 32'd0);
    check("rst_flush_cnt", flush_count, 32'd0);
    check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    check("run_idle", {18'd0, ctrl}, {18'd0, C_IDLE});

    // 2. Load-use on rs, then no hazard for r0, then load-use on rt.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    check("lu_rs", {18'd0, ctrl}, {18'd0, C_LU});
    idle();
    check("lu_rs_after", {18'd0, ctrl}, {18'd0, C_IDLE});
    check("lu_rs_stall_cnt", stall_count, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    check("lu_r0", {18'd0, ctrl}, {18'd0, C_IDLE});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
    check("lu_rt", {18'd0, ctrl}, {18'd0, C_LU});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
    check("lu_rt_unused", {18'd0, ctrl}, {18'd0, C_IDLE});
    idle();
    check("lu_stall_cnt", stall_count, 32'd2);

    // 3. Three wait cycles then release; zero-wait access afterwards.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mw_c1", {18'd0, ctrl}, {18'd0, C_WAIT});
    check("mw_c1_state", {30'd0, state}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mw_c2", {18'd0, ctrl}, {18'd0, C_WAIT});
    check("mw_c2_state", {30'd0, state}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mw_c3", {18'd0, ctrl}, {18'd0, C_WAIT});
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mw_release", {18'd0, ctrl}, {18'd0, C_IDLE});
    check("mw_release_state", {30'd0, state}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mw_back_run", {30'd0, state}, 32'd0);
    check("mw_stall_cnt", stall_count, 32'd5);
    check("zero_wait", {18'd0, ctrl}, {18'd0, C_IDLE});
    idle();
    check("zero_wait_state", {30'd0, state}, 32'd0);

    // 4. Mispredict during MEM_WAIT, redirect only on the release cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mwp_c1", {18'd0, ctrl}, {18'd0, C_WAIT});
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mwp_c2_mispr", {18'd0, ctrl}, {18'd0, C_WAIT});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mwp_c3", {18'd0, ctrl}, {18'd0, C_WAIT});
    check("mwp_no_flush_yet", flush_count, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mwp_release_redir", {18'd0, ctrl}, {18'd0, C_REDIR});
    idle();
    check("mwp_after", {18'd0, ctrl}, {18'd0, C_IDLE});
    check("mwp_flush_cnt", flush_count, 32'd1);
    check("mwp_stall_cnt", stall_count, 32'd8);
    check("mwp_state", {30'd0, state}, 32'd0);

    // 5. Mispredict coincident with load-use in RUN: redirect wins.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    check("mispr_over_lu", {18'd0, ctrl}, {18'd0, C_REDIR});
    idle();
    check("mispr_flush_cnt", flush_count, 32'd2);
    check("mispr_stall_cnt", stall_count, 32'd8);

    // 6a. mem_ready on the 4th wait cycle: no error.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("to_edge_wait", {18'd0, ctrl}, {18'd0, C_WAIT});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("to_edge_release", {18'd0, ctrl}, {18'd0, C_IDLE});
    idle();
    check("to_edge_state", {30'd0, state}, 32'd0);
    check("to_edge_no_err", {31'd0, mem_timeout}, 32'd0);
    check("to_edge_stall_cnt", stall_count, 32'd11);

    // 6b. mem_ready held low: ERROR after four wait cycles, sticky.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("to_wait", {18'd0, ctrl}, {18'd0, C_WAIT});
    end
    check("to_not_yet", {31'd0, mem_timeout}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("err_state", {30'd0, state}, 32'd2);
    check("err_flag", {31'd0, mem_timeout}, 32'd1);
    check("err_ctrl", {18'd0, ctrl}, {18'd0, C_WAIT});
    idle();
    check("err_sticky_state", {30'd0, state}, 32'd2);
    check("err_sticky_flag", {31'd0, mem_timeout}, 32'd1);
    check("err_stall_cnt", stall_count, 32'd15);

    // Reset clears the error.
    @(negedge clk); reset_n = 1'b0; #1;
    check("err_rst_ctrl", {18'd0, ctrl}, {18'd0, C_RESET});
    @(negedge clk); reset_n = 1'b1; #1;
    check("err_rst_state", {30'd0, state}, 32'd0);
    check("err_rst_flag", {31'd0, mem_timeout}, 32'd0);
    check("err_rst_stall_cnt", stall_count, 32'd0);
    check("err_rst_flush_cnt", flush_count, 32'd0);
    check("err_rst_idle", {18'd0, ctrl}, {18'd0, C_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
